// File: rtl/sprdma_pkg.sv
// Shared NES bus constants and the sprdma state encoding.
package sprdma_pkg;

  localparam logic [15:0] NES_DMA_REG_ADDR  = 16'h4014;
  localparam logic [15:0] NES_OAM_DATA_ADDR = 16'h2004;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } sprdma_state_e;

endpackage

// File: rtl/sprdma.sv
// Sprite (OAM) DMA: halts the CPU on a write to DMA_REG_ADDR and copies one page to OAMDATA.
// Optional macro SPRDMA_ODD_ALIGN_EN inserts an ALIGN cycle when HALT ends on odd cycle parity.
module sprdma
  import sprdma_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = NES_DMA_REG_ADDR,
  parameter logic [15:0] OAM_DATA_ADDR = NES_OAM_DATA_ADDR,
  parameter int unsigned HALT_CYCLES   = 1
) (
  input  logic        clk,
  input  logic        nres,
  input  logic [15:0] cpu_a,
  input  logic        cpu_r_nw,
  input  logic [7:0]  cpu_dout,
  input  logic        dbg_ready,
  input  logic [7:0]  cpumc_dout,
  output logic        cpu_ready,
  output logic        bus_req,
  output logic [15:0] a,
  output logic        r_nw,
  output logic [7:0]  dout,
  output logic        active
);

  localparam logic [1:0] HALT_LAST = 2'(HALT_CYCLES - 1);

  sprdma_state_e state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    page_q, page_d;
  logic [1:0]    halt_cnt_q, halt_cnt_d;
  logic          paused;

`ifdef SPRDMA_ODD_ALIGN_EN
  logic parity_q, parity_d;

  assign parity_d = ~parity_q;

  always_ff @(posedge clk or negedge nres) begin
    if (!nres) parity_q <= 1'b0;
    else       parity_q <= parity_d;
  end
`endif

  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      page_q     <= '0;
      halt_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      page_q     <= page_d;
      halt_cnt_q <= halt_cnt_d;
    end
  end

  assign paused = (state_q != ST_IDLE) && !dbg_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    page_d     = page_q;
    halt_cnt_d = halt_cnt_q;
    cpu_ready  = (state_q == ST_IDLE);
    active     = (state_q != ST_IDLE);
    bus_req    = 1'b0;
    a          = '0;
    r_nw       = 1'b1;
    dout       = '0;

    case (state_q)
      ST_IDLE: begin
        if (dbg_ready && (cpu_a == DMA_REG_ADDR) && !cpu_r_nw) begin
          page_d     = cpu_dout;
          cnt_d      = '0;
          halt_cnt_d = '0;
          state_d    = ST_HALT;
        end
      end
      ST_HALT: begin
        if (!paused) begin
          if (halt_cnt_q == HALT_LAST) begin
            halt_cnt_d = '0;
`ifdef SPRDMA_ODD_ALIGN_EN
            state_d    = parity_q ? ST_ALIGN : ST_READ;
`else
            state_d    = ST_READ;
`endif
          end else begin
            halt_cnt_d = halt_cnt_q + 2'd1;
          end
        end
      end
`ifdef SPRDMA_ODD_ALIGN_EN
      ST_ALIGN: begin
        if (!paused) state_d = ST_READ;
      end
`endif
      ST_READ: begin
        if (!paused) begin
          bus_req = 1'b1;
          a       = {page_q, cnt_q};
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // A pause here invalidates the read data, so the byte is re-read on resume.
        if (paused) begin
          state_d = ST_READ;
        end else begin
          bus_req = 1'b1;
          a       = OAM_DATA_ADDR;
          r_nw    = 1'b0;
          dout    = cpumc_dout;
          cnt_d   = cnt_q + 8'd1;
          state_d = (cnt_q == 8'hFF) ? ST_DONE : ST_READ;
        end
      end
      ST_DONE: begin
        if (!paused) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sprdma.sv
// Self-checking bench for sprdma: memory model, bus monitor and per-scenario checks.
module tb_sprdma;

  logic        clk;
  logic        nres;
  logic [15:0] cpu_a;
  logic        cpu_r_nw;
  logic [7:0]  cpu_dout;
  logic        dbg_ready;
  logic [7:0]  cpumc_dout;
  logic        cpu_ready;
  logic        bus_req;
  logic [15:0] a;
  logic        r_nw;
  logic [7:0]  dout;
  logic        active;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  mem [0:65535];
  logic [15:0] rd_q[$];
  logic [15:0] wr_a_q[$];
  logic [7:0]  wr_d_q[$];
  int          low_cnt, act_mis, pause_bus;
  int unsigned ecnt;

  sprdma dut (
    .clk        (clk),
    .nres       (nres),
    .cpu_a      (cpu_a),
    .cpu_r_nw   (cpu_r_nw),
    .cpu_dout   (cpu_dout),
    .dbg_ready  (dbg_ready),
    .cpumc_dout (cpumc_dout),
    .cpu_ready  (cpu_ready),
    .bus_req    (bus_req),
    .a          (a),
    .r_nw       (r_nw),
    .dout       (dout),
    .active     (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory returns data the cycle after the address; the bus is DMA-owned when bus_req=1.
  always @(posedge clk) cpumc_dout <= mem[bus_req ? a : cpu_a];

  // Clock edges since reset release, used to predict the cycle parity.
  always @(posedge clk or negedge nres) begin
    if (!nres) ecnt <= 0;
    else       ecnt <= ecnt + 1;
  end

  always @(negedge clk) begin
    if (cpu_ready === 1'b0) low_cnt++;
    if (active !== !cpu_ready) act_mis++;
    if (!dbg_ready && bus_req) pause_bus++;
    if (bus_req === 1'b1) begin
      if (r_nw) rd_q.push_back(a);
      else begin
        wr_a_q.push_back(a);
        wr_d_q.push_back(dout);
      end
    end
  end

  task automatic drive_idle();
    cpu_a    = 16'($urandom_range(0, 16'h3FFF));
    cpu_r_nw = 1'($urandom);
    cpu_dout = 8'($urandom);
  endtask

  task automatic clear_logs();
    rd_q.delete();
    wr_a_q.delete();
    wr_d_q.delete();
    low_cnt   = 0;
    act_mis   = 0;
    pause_bus = 0;
  endtask

  // Issues a CPU write of pg to the DMA register; returns the expected extra ALIGN cycle.
  task automatic do_trigger(input logic [7:0] pg, output int extra);
    @(posedge clk);
    #1;
    clear_logs();
    cpu_a    = 16'h4014;
    cpu_r_nw = 1'b0;
    cpu_dout = pg;
    @(posedge clk);
    #1;
`ifdef SPRDMA_ODD_ALIGN_EN
    extra = int'(ecnt % 2);
`else
    extra = 0;
`endif
    drive_idle();
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (cpu_ready === 1'b1 && active === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    nres      = 1'b0;
    dbg_ready = 1'b1;
    drive_idle();
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if ({cpu_ready, bus_req, a, r_nw, dout, active} !== {1'b1, 1'b0, 16'h0000, 1'b1, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got ready=%b req=%b a=%h rnw=%b dout=%h act=%b", cpu_ready, bus_req, a, r_nw, dout, active);
    end
    nres = 1'b1;
  endtask

  task automatic test_basic();
    int extra;
    bit ok;
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i);
    do_trigger(8'h02, extra);
    @(negedge clk);
    n_checks++;
    if (cpu_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_ready_fall: got %b want 0", cpu_ready);
    end
    wait_done(ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL basic_timeout: got %b want 1", ok); end
    n_checks++;
    if (low_cnt != 514 + extra) begin
      n_fail++;
      $display("FAIL basic_low_cycles: got %0d want %0d", low_cnt, 514 + extra);
    end
    n_checks++;
    if (act_mis != 0) begin n_fail++; $display("FAIL basic_active_tracks_ready: got %0d want 0", act_mis); end
    n_checks++;
    if (wr_d_q.size() != 256) begin
      n_fail++;
      $display("FAIL basic_write_count: got %0d want 256", wr_d_q.size());
    end else begin
      for (int i = 0; i < 256; i++) begin
        n_checks++;
        if (wr_a_q[i] !== 16'h2004 || wr_d_q[i] !== 8'(i)) begin
          n_fail++;
          $display("FAIL basic_write[%0d]: got %h<=%h want 2004<=%h", i, wr_a_q[i], wr_d_q[i], 8'(i));
        end
      end
    end
  endtask

  task automatic test_page7();
    int extra;
    bit ok;
    int bad_rd, bad_wr;
    for (int i = 0; i < 512; i++) mem[16'h0700 + i] = 8'($urandom);
    do_trigger(8'h07, extra);
    wait_done(ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL page7_timeout: got %b want 1", ok); end
    n_checks++;
    if (rd_q.size() != 256 || wr_d_q.size() != 256) begin
      n_fail++;
      $display("FAIL page7_counts: got rd=%0d wr=%0d want 256/256", rd_q.size(), wr_d_q.size());
    end else begin
      n_checks++;
      if (rd_q[0] !== 16'h0700 || rd_q[255] !== 16'h07FF) begin
        n_fail++;
        $display("FAIL page7_first_last: got %h/%h want 0700/07FF", rd_q[0], rd_q[255]);
      end
      bad_rd = 0;
      bad_wr = 0;
      for (int i = 0; i < 256; i++) begin
        if (rd_q[i] !== 16'h0700 + 16'(i)) bad_rd++;
        if (wr_d_q[i] !== mem[16'h0700 + i] || wr_a_q[i] !== 16'h2004) bad_wr++;
      end
      n_checks++;
      if (bad_rd != 0) begin n_fail++; $display("FAIL page7_read_order: got %0d bad want 0", bad_rd); end
      n_checks++;
      if (bad_wr != 0) begin n_fail++; $display("FAIL page7_write_data: got %0d bad want 0", bad_wr); end
    end
    n_checks++;
    if (low_cnt != 514 + extra) begin
      n_fail++;
      $display("FAIL page7_low_cycles: got %0d want %0d", low_cnt, 514 + extra);
    end
  endtask

  task automatic test_debug_pause();
    int extra;
    bit ok, found;
    int bad_rd, bad_wr;
    logic [7:0]  pg;
    logic [15:0] exp_a;
    pg = 8'($urandom_range(8'h10, 8'h7F));
    for (int i = 0; i < 256; i++) mem[{pg, 8'(i)}] = 8'($urandom);
    do_trigger(pg, extra);
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus_req === 1'b1 && r_nw === 1'b1 && a === {pg, 8'h40}) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++;
    if (found !== 1'b1) begin n_fail++; $display("FAIL pause_reach_cnt40: got %b want 1", found); end
    @(posedge clk);
    #1 dbg_ready = 1'b0;
    repeat (10) @(posedge clk);
    #1 dbg_ready = 1'b1;
    wait_done(ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL pause_timeout: got %b want 1", ok); end
    n_checks++;
    if (pause_bus != 0) begin n_fail++; $display("FAIL pause_bus_req: got %0d want 0", pause_bus); end
    n_checks++;
    if (low_cnt != 525 + extra) begin
      n_fail++;
      $display("FAIL pause_low_cycles: got %0d want %0d", low_cnt, 525 + extra);
    end
    n_checks++;
    if (rd_q.size() != 257 || wr_d_q.size() != 256) begin
      n_fail++;
      $display("FAIL pause_counts: got rd=%0d wr=%0d want 257/256", rd_q.size(), wr_d_q.size());
    end else begin
      bad_rd = 0;
      bad_wr = 0;
      for (int i = 0; i < 257; i++) begin
        exp_a = {pg, 8'((i <= 8'h40) ? i : i - 1)};
        if (rd_q[i] !== exp_a) bad_rd++;
      end
      for (int i = 0; i < 256; i++)
        if (wr_d_q[i] !== mem[{pg, 8'(i)}] || wr_a_q[i] !== 16'h2004) bad_wr++;
      n_checks++;
      if (bad_rd != 0) begin n_fail++; $display("FAIL pause_reread: got %0d bad reads want 0", bad_rd); end
      n_checks++;
      if (bad_wr != 0) begin n_fail++; $display("FAIL pause_write_seq: got %0d bad writes want 0", bad_wr); end
    end
  endtask

  task automatic test_reset_mid();
    int extra;
    bit ok, found;
    int bad_wr;
    logic [7:0] pg;
    pg = 8'($urandom_range(8'h80, 8'hFE));
    for (int i = 0; i < 256; i++) mem[{pg, 8'(i)}] = 8'($urandom);
    do_trigger(pg, extra);
    found = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (bus_req === 1'b1 && r_nw === 1'b1 && a === {pg, 8'h80}) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++;
    if (found !== 1'b1) begin n_fail++; $display("FAIL rstmid_reach_cnt80: got %b want 1", found); end
    #2 nres = 1'b0;
    #1;
    n_checks++;
    if ({cpu_ready, bus_req, a, r_nw, dout, active} !== {1'b1, 1'b0, 16'h0000, 1'b1, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL rstmid_async_outputs: got ready=%b req=%b a=%h rnw=%b dout=%h act=%b", cpu_ready, bus_req, a, r_nw, dout, active);
    end
    @(posedge clk);
    #2 nres = 1'b1;
    do_trigger(pg, extra);
    wait_done(ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL rstmid_timeout: got %b want 1", ok); end
    n_checks++;
    if (rd_q.size() == 0 || rd_q[0] !== {pg, 8'h00}) begin
      n_fail++;
      $display("FAIL rstmid_fresh_start: got %0d reads first=%h want first %h", rd_q.size(), (rd_q.size() != 0) ? rd_q[0] : 16'hxxxx, {pg, 8'h00});
    end
    n_checks++;
    if (wr_d_q.size() != 256) begin
      n_fail++;
      $display("FAIL rstmid_write_count: got %0d want 256", wr_d_q.size());
    end else begin
      bad_wr = 0;
      for (int i = 0; i < 256; i++) if (wr_d_q[i] !== mem[{pg, 8'(i)}]) bad_wr++;
      n_checks++;
      if (bad_wr != 0) begin n_fail++; $display("FAIL rstmid_write_data: got %0d bad want 0", bad_wr); end
    end
    n_checks++;
    if (low_cnt != 514 + extra) begin
      n_fail++;
      $display("FAIL rstmid_low_cycles: got %0d want %0d", low_cnt, 514 + extra);
    end
  endtask

  task automatic test_no_trigger();
    @(posedge clk);
    #1;
    clear_logs();
    cpu_a    = 16'h4014;
    cpu_r_nw = 1'b1;
    cpu_dout = 8'($urandom);
    @(posedge clk);
    #1;
    cpu_r_nw  = 1'b0;
    dbg_ready = 1'b0;
    @(posedge clk);
    #1;
    dbg_ready = 1'b1;
    drive_idle();
    repeat (20) @(negedge clk);
    n_checks++;
    if (low_cnt != 0) begin n_fail++; $display("FAIL notrig_ready_low: got %0d cycles want 0", low_cnt); end
    n_checks++;
    if (active !== 1'b0 || rd_q.size() != 0) begin
      n_fail++;
      $display("FAIL notrig_activity: got active=%b reads=%0d want 0/0", active, rd_q.size());
    end
  endtask

`ifdef SPRDMA_ODD_ALIGN_EN
  task automatic test_align();
    int extra;
    bit ok;
    for (int want = 0; want < 2; want++) begin
      @(negedge clk);
      if (ecnt % 2 != want) @(negedge clk);
      do_trigger(8'h02, extra);
      wait_done(ok);
      n_checks++;
      if (ok !== 1'b1 || low_cnt != 514 + want) begin
        n_fail++;
        $display("FAIL align_parity%0d: got %0d cycles want %0d", want, low_cnt, 514 + want);
      end
    end
  endtask
`endif

  initial begin
    cpumc_dout = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    test_reset();
    repeat (3) @(posedge clk);
    test_basic();
    test_page7();
    test_debug_pause();
    test_reset_mid();
    test_no_trigger();
`ifdef SPRDMA_ODD_ALIGN_EN
    test_align();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sprdma.md
Name: sprdma

Overview:
- Sprite (OAM) DMA controller for the CPU memory bus.
- Snoops CPU writes to 0x4014. On such a write, it halts the CPU through its READY line and takes over the cpumc bus.
- Copies 256 bytes from CPU page {page,00}..{page,FF} to PPU register 0x2004 (OAMDATA) as read/write pairs, then releases the bus.
- Sits beside the top-level cpumc mux, which selects sprdma outputs whenever bus_req=1.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address that triggers a transfer.
- OAM_DATA_ADDR, 16'h2004, destination address written each byte.
- HALT_CYCLES, 1, idle cycles with READY low before the first read (1..4).

Ports:
- clk  in  1  system clock (CLK_50MHZ domain)
- nres  in  1  asynchronous active-low reset
- cpu_a  in  16  CPU address output (snooped)
- cpu_r_nw  in  1  CPU R/!W (snooped)
- cpu_dout  in  8  CPU write data (snooped; carries the page number)
- dbg_ready  in  1  debugger run state; 0 = debug break in progress
- cpumc_dout  in  8  memory read data; valid the cycle after the address is presented
- cpu_ready  out  1  READY to CPU; 0 halts the CPU
- bus_req  out  1  1 = top-level mux routes a/r_nw/dout below onto the cpumc bus
- a  out  16  DMA address
- r_nw  out  1  DMA R/!W
- dout  out  8  DMA write data
- active  out  1  transfer in progress (including paused)

Behaviour:
- Reset (nres=0, async): state=IDLE, cnt=0, page=0, halt_cnt=0. Outputs: cpu_ready=1, bus_req=0, a=0, r_nw=1, dout=0, active=0.
- Trigger: at a clk edge in IDLE with dbg_ready=1, cpu_a==DMA_REG_ADDR and cpu_r_nw==0:
  - page<=cpu_dout, cnt<=0, state<=HALT.
  - Triggers in any other state are ignored.
  - Debugger writes (dbg_ready=0) never trigger.
- States:
  - IDLE: cpu_ready=1, bus_req=0.
  - HALT: cpu_ready=0, bus_req=0. Lasts HALT_CYCLES cycles, then goes to READ (or ALIGN, see Optional Feature).
  - READ: cpu_ready=0, bus_req=1, a={page,cnt}, r_nw=1. Next state WRITE.
  - WRITE: bus_req=1, a=OAM_DATA_ADDR, r_nw=0, dout=cpumc_dout (pass-through).
    - cnt<=cnt+1 (8-bit, wraps).
    - If cnt==8'hFF, state<=DONE; otherwise state<=READ.
  - DONE: cpu_ready=0, bus_req=0, for one cycle; then IDLE. cpu_ready returns to 1 in the cycle after DONE.
- Outside READ/WRITE: a=0, r_nw=1, dout=0.
- active=1 in HALT/ALIGN/READ/WRITE/DONE.
- Latency, with HALT_CYCLES=1 and no alignment:
  - trigger edge to first READ: 1 cycle of HALT.
  - total cpu_ready low: 1+512+1 = 514 cycles.
- Debug pause (dbg_ready=0 while active):
  - state, cnt and page are frozen; bus_req=0; a/r_nw/dout at idle values; cpu_ready stays 0.
  - If paused in WRITE, resume in READ with the same cnt, because the read data is stale. Other states resume where they stopped.
- Page wrap: cnt wraps 0xFF->0x00 only at the transition to DONE. The address never carries into page+1.
- Reset mid-transfer: immediate abort to reset values; partially written OAM is left as-is.
- Trigger page 0x20 (PPU range) is legal: reads go to 0x20xx as normal; no special casing.

Optional Feature:
- Macro SPRDMA_ODD_ALIGN_EN.
- Defined:
  - A free-running 1-bit cycle parity toggles every clk edge (reset 0).
  - If parity==1 when HALT completes, one extra ALIGN state (cpu_ready=0, bus_req=0) is inserted before READ. Total is then 515 cycles.
- Undefined: no ALIGN state, no parity register; HALT goes directly to READ.

Decomposition:
- Shared package/include nes_defs holds:
  - address constants 16'h4014 and 16'h2004 (also used by top-level decode);
  - the sprdma state encoding localparams (IDLE, HALT, ALIGN, READ, WRITE, DONE, 3-bit).
- No sub-module: a single flat FSM with an 8-bit counter and halt counter; the block is small.
- Top-level change: the cpumc mux priority becomes bus_req, then cpu_ready-qualified CPU, then debugger.

Test Plan:
- Fill RAM 0x0200..0x02FF with value=index. CPU writes 0x02 to 0x4014. Required:
  - cpu_ready falls the next cycle;
  - 256 writes to 0x2004 with data 0x00..0xFF in order;
  - cpu_ready low for exactly 514 cycles;
  - active falls with cpu_ready.
- Trigger with page 0x07: the first READ address is 0x0700 and the last is 0x07FF; no access to 0x0800.
- Drop dbg_ready for 10 cycles while in WRITE with cnt=0x40. Required:
  - bus_req=0 during the pause;
  - on resume, READ at {page,40} is re-issued;
  - the 0x2004 write sequence has no gap or duplicate.
- Assert nres at cnt=0x80. Required: outputs go to reset values asynchronously; a subsequent 0x4014 write starts a fresh transfer from cnt=0.
- CPU read of 0x4014, and a debugger write to 0x4014 with dbg_ready=0 -> no transfer; cpu_ready stays 1.
- With SPRDMA_ODD_ALIGN_EN defined, trigger once at even parity and once at odd parity -> cpu_ready low for 514 and 515 cycles respectively.
